// File: rtl/i2c_scl_gen_pkg.sv
// rtl/i2c_scl_gen_pkg.sv - shared types and constants for the I2C SCL generator
// Contents: state_e (IDLE, Q0..Q3 quarter phases), SYNC_STAGES (pad synchronizer depth).
package i2c_pkg;

  // Q0/Q1 hold SCL low, Q2/Q3 release it.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Q0   = 3'd1,
    Q1   = 3'd2,
    Q2   = 3'd3,
    Q3   = 3'd4
  } state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// rtl/i2c_scl_gen_if.sv - control/strobe bundle between byte engine and SCL generator
// Signals: en, div (quarter period), scl_in (raw pad) toward the generator;
//          scl_oe, busy, fall/chg/rise/smp strobes, stretch back to the byte engine.
// Modports: master = byte engine side, slave = SCL generator.
interface i2c_scl_gen_if #(
  parameter int DIV_W = 16
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic             scl_in;
  logic             scl_oe;
  logic             busy;
  logic             fall_stb;
  logic             chg_stb;
  logic             rise_stb;
  logic             smp_stb;
  logic             stretch;

  modport master (
    output en, div, scl_in,
    input  scl_oe, busy, fall_stb, chg_stb, rise_stb, smp_stb, stretch
  );

  modport slave (
    input  en, div, scl_in,
    output scl_oe, busy, fall_stb, chg_stb, rise_stb, smp_stb, stretch
  );
endinterface

// File: rtl/i2c_scl_gen_sync2.sv
// rtl/i2c_scl_gen_sync2.sv - 2-flop synchronizer (reset value 1) for I2C pad inputs
// Ports: clk, rst_n (async active-low), d (asynchronous input), q (synchronized output).
module i2c_sync2
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Reset to 1: an idle I2C bus line is pulled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - programmable I2C SCL generator with quarter-phase strobes
// Ports: clk, rst_n (async active-low), bus (i2c_scl_gen_if.slave): en, div, scl_in in;
//        scl_oe, busy, fall_stb, chg_stb, rise_stb, smp_stb, stretch out.
// Macro I2C_SCL_STRETCH_EN: synchronize scl_in and hold the high phase while a slave stretches.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV_W = 16
)
(
  input  logic         clk,
  input  logic         rst_n,
  i2c_scl_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_eff;
  logic             scl_oe_q, scl_oe_d;
  logic             busy_q, busy_d;
  logic             fall_q, fall_d;
  logic             chg_q, chg_d;
  logic             rise_q, rise_d;
  logic             smp_q, smp_d;
  logic             stretch_q, stretch_d;
  logic             scl_s;
  logic             last;

`ifdef I2C_SCL_STRETCH_EN
  i2c_sync2 u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.scl_in),
    .q     (scl_s)
  );
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.scl_in;
  assign scl_s         = 1'b1;
`endif

  always_comb begin
    div_eff = (bus.div == '0) ? ONE : bus.div;
    last    = (cnt_q == div_q - ONE);
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    div_d   = div_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = Q0;
          div_d   = div_eff;
        end
      end
      Q0: begin
        if (last) begin
          state_d = Q1;
          cnt_d   = '0;
        end
      end
      Q1: begin
        if (last) begin
          state_d = Q2;
          cnt_d   = '0;
        end
      end
      Q2: begin
        // A slave holding SCL low freezes the high-phase count.
        if (!scl_s) begin
          cnt_d = cnt_q;
        end else if (last) begin
          state_d = Q3;
          cnt_d   = '0;
        end
      end
      Q3: begin
        // en is only looked at here, so a period is never cut short.
        if (last) begin
          cnt_d = '0;
          if (bus.en) begin
            state_d = Q0;
            div_d   = div_eff;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so they register alongside it.
    scl_oe_d = (state_d == Q0) || (state_d == Q1);
    busy_d   = (state_d != IDLE);
    fall_d   = (state_d == Q0) && (state_q != Q0);
    chg_d    = (state_d == Q1) && (state_q != Q1);
    rise_d   = (state_d == Q2) && (state_q != Q2);
    smp_d    = (state_d == Q3) && (state_q != Q3);

`ifdef I2C_SCL_STRETCH_EN
    // rise_q marks the first Q2 cycle; from the second onward a low scl_s is a stretch.
    stretch_d = (state_q == Q2) && !scl_s && !rise_q;
`else
    stretch_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= ONE;
      scl_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      fall_q    <= 1'b0;
      chg_q     <= 1'b0;
      rise_q    <= 1'b0;
      smp_q     <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      scl_oe_q  <= scl_oe_d;
      busy_q    <= busy_d;
      fall_q    <= fall_d;
      chg_q     <= chg_d;
      rise_q    <= rise_d;
      smp_q     <= smp_d;
      stretch_q <= stretch_d;
    end
  end

  assign bus.scl_oe   = scl_oe_q;
  assign bus.busy     = busy_q;
  assign bus.fall_stb = fall_q;
  assign bus.chg_stb  = chg_q;
  assign bus.rise_stb = rise_q;
  assign bus.smp_stb  = smp_q;
  assign bus.stretch  = stretch_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb/tb_i2c_scl_gen.sv - scoreboard bench for i2c_scl_gen with a period-level reference model
module tb_i2c_scl_gen;

  localparam int DIV_W = 16;
`ifdef I2C_SCL_STRETCH_EN
  localparam bit STRETCH = 1'b1;
  localparam int EXTRA   = 2;
`else
  localparam bit STRETCH = 1'b0;
  localparam int EXTRA   = 0;
`endif
  localparam int FAR = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst_n;
  logic force_low;

  always #5 clk = ~clk;

  i2c_scl_gen_if #(.DIV_W(DIV_W)) bus ();

  // Ideal open-drain bus unless the bench plays a slave holding SCL low.
  assign bus.scl_in = force_low ? 1'b0 : ~bus.scl_oe;

  i2c_scl_gen #(.DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  // Reference model: one SCL period at a time, timed by arithmetic on the
  // period start s and quarter length N (fall s, chg s+N, rise s+2N, smp s+3N).
  bit running = 1'b0;
  int p_n, p_r, p_q3, p_end, ones;
  bit sh_a = 1'b1, scl_s_now = 1'b1, prev_cond = 1'b0;
  bit exp_oe = 1'b0, exp_busy = 1'b0, exp_str = 1'b0;

  always @(posedge clk) begin
    bit cond;
    cyc++;
    if (!rst_n) begin
      running   = 1'b0;
      exp_q.delete();
      sh_a      = 1'b1;
      scl_s_now = 1'b1;
      prev_cond = 1'b0;
      exp_oe    = 1'b0;
      exp_busy  = 1'b0;
      exp_str   = 1'b0;
    end else begin
      // scl_s in this cycle equals scl_in two cycles ago.
      scl_s_now = sh_a;
      sh_a      = bus.scl_in;
      exp_str   = prev_cond;
      if (running && cyc == p_end) running = 1'b0;
      if (!running && bus.en) begin
        running = 1'b1;
        p_n     = (bus.div == 0) ? 1 : int'(bus.div);
        p_r     = cyc + 2 * p_n;
        ones    = 0;
        push_ev(0, cyc);
        push_ev(1, cyc + p_n);
        push_ev(2, p_r);
        if (STRETCH) begin
          p_q3  = -1;
          p_end = FAR;
        end else begin
          p_q3  = cyc + 3 * p_n;
          p_end = cyc + 4 * p_n;
          push_ev(3, p_q3);
        end
      end
      cond = 1'b0;
      // High phase ends after N cycles in which the synchronized line read high.
      if (STRETCH && running && cyc >= p_r && p_q3 < 0) begin
        cond = !scl_s_now && (cyc != p_r);
        if (scl_s_now) ones++;
        if (ones == p_n) begin
          p_q3  = cyc + 1;
          p_end = p_q3 + p_n;
          push_ev(3, p_q3);
        end
      end
      prev_cond = cond;
      exp_oe    = running && (cyc < p_r);
      exp_busy  = running;
    end
  end

  // Monitor: compares levels every cycle and pops one expected event per strobe.
  always @(negedge clk) begin
    logic [3:0] stb;
    ev_t e;
    if (!rst_n) begin
      check("reset_outs", int'({bus.scl_oe, bus.busy, bus.fall_stb, bus.chg_stb,
                                bus.rise_stb, bus.smp_stb, bus.stretch}), 0);
    end else begin
      check("busy", int'(bus.busy), int'(exp_busy));
      check("scl_oe", int'(bus.scl_oe), int'(exp_oe));
      check("stretch", int'(bus.stretch), int'(exp_str));
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_strobe: kind %0d due at cycle %0d not seen, now %0d",
                 exp_q[0].kind, exp_q[0].at, cyc);
        e = exp_q.pop_front();
      end
      stb = {bus.smp_stb, bus.rise_stb, bus.chg_stb, bus.fall_stb};
      for (int k = 0; k < 4; k++) begin
        if (stb[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: kind %0d at cycle %0d, expected none", k, cyc);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind", k, e.kind);
            check("strobe_cycle", cyc, e.at);
          end
        end
      end
    end
  end

  task automatic wait_stb(input int which, output int at);
    logic [3:0] s;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      s = {bus.smp_stb, bus.rise_stb, bus.chg_stb, bus.fall_stb};
      if (s[which]) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout_strobe: strobe %0d not seen, got none, expected one within 400 cycles", which);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_idle: busy got 1, expected 0 within 400 cycles");
  endtask

  initial begin
    int a, b, c, d, e, n, rel;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.div   = 16'd4;
    force_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Free-running at div=4.
    bus.div = 16'd4;
    bus.en  = 1'b1;
    wait_stb(0, a);
    wait_stb(0, b);
    check("period_div4", b - a, 16 + EXTRA);
    repeat (20) @(negedge clk);
    bus.en = 1'b0;
    wait_idle();

    // div=0 behaves as 1; a change during Q1 waits for the next period.
    bus.div = 16'd0;
    bus.en  = 1'b1;
    wait_stb(0, a);
    wait_stb(0, b);
    check("period_div0", b - a, 4 + EXTRA);
    wait_stb(1, c);
    bus.div = 16'd3;
    wait_stb(0, d);
    check("period_before_change", d - (c - 1), 4 + EXTRA);
    wait_stb(0, e);
    check("period_after_change", e - d, 12 + EXTRA);

    // Slave holds SCL low for 20 cycles after rise_stb.
    bus.div = 16'd4;
    wait_stb(0, a);
    wait_stb(2, a);
    force_low = 1'b1;
    repeat (20) @(negedge clk);
    force_low = 1'b0;
    wait_stb(0, a);
    wait_stb(0, b);
    check("period_after_stretch", b - a, 16 + EXTRA);
    bus.en = 1'b0;
    wait_idle();

    // Single-cycle en pulse gives exactly one period.
    repeat (3) @(negedge clk);
    bus.div = 16'd2;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("pulse_busy_cycles", n, 8 + EXTRA);
    repeat (10) @(negedge clk);

    // Asynchronous reset in Q0, then restart with en held high.
    bus.div = 16'd3;
    bus.en  = 1'b1;
    wait_stb(0, a);
    #2 rst_n = 1'b0;
    #1 check("async_reset", int'({bus.scl_oe, bus.busy, bus.fall_stb}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
    wait_stb(0, b);
    check("fall_after_release", b - rel, 1);

    // Randomized traffic: div, en and slave stretching.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.div   = DIV_W'($urandom_range(0, 5));
      bus.en    = 1'($urandom_range(0, 1));
      force_low = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    bus.en    = 1'b0;
    force_low = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Parametrised I2C SCL generator for the I2C master: divides the system clock to a programmable SCL rate and drives SCL open-drain (`scl_oe` high pulls the line low). It emits one-cycle quarter-phase strobes that tell the byte engine when to change SDA and when to sample it. With stretching compiled in, it holds the high phase while a slave keeps SCL low. It replaces the fixed-rate phase-shifted clock outputs with strobes in the `clk` domain.

## Interface
- `DIV_W`, 16: width of the quarter-period divider input.
- `clk`  in  1  system clock; every flop is rising-edge `clk`.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  level request to run SCL; sampled every cycle.
- `div`  in  `DIV_W`  quarter-period length N in `clk` cycles; 0 is treated as 1.
- `scl_in`  in  1  raw SCL pad input, asynchronous.
- `scl_oe`  out  1  1 = drive SCL low; 0 = release.
- `busy`  out  1  state is not IDLE.
- `fall_stb`  out  1  pulse: SCL just driven low.
- `chg_stb`  out  1  pulse: mid-low, SDA may change.
- `rise_stb`  out  1  pulse: SCL just released.
- `smp_stb`  out  1  pulse: mid-high, sample SDA.
- `stretch`  out  1  slave is holding SCL low during the high phase.

## Operation
- States: IDLE, Q0 (low), Q1 (low), Q2 (high), Q3 (high).
- `scl_oe` is 1 in Q0 and Q1, and 0 in IDLE, Q2 and Q3.
- Reset: state IDLE; counter 0; `div_q` 1; every output 0.
- Entering Q0: `div_q` loads `max(div, 1)`. `div` changes mid-period have no effect until the next Q0.
- Counter `cnt` (`DIV_W` bits) clears on each state entry and advances each cycle. The state advances when `cnt == div_q-1`.
- IDLE -> Q0 when `en` = 1.
- Q0 -> Q1 -> Q2 -> Q3 in sequence.
- Q3 -> Q0 if `en` = 1, else -> IDLE.
- Dropping `en` never truncates a period. The current Q3 always completes.
- Strobes: each is a one-cycle pulse on the first cycle of its state.
  - `fall_stb`: Q0.
  - `chg_stb`: Q1.
  - `rise_stb`: Q2.
  - `smp_stb`: Q3.
  - All strobes are registered alongside the state, never combinational from `en`.
- All outputs are registered.

## Timing
- `en` rises at cycle t: Q0 at t+1, with `scl_oe` = 1 and `fall_stb` = 1.
- Base period is 4N cycles. Low time and high time are 2N cycles each.
- `en` low with the state in IDLE: outputs stay at reset values. `en` high for a single cycle: exactly one full SCL period.
- `rst_n` asserted mid-period: `scl_oe`, `busy` and the strobes drop asynchronously, the same cycle. On release, the block returns to IDLE.

## Configuration
- Macro: `I2C_SCL_STRETCH_EN`.
- Defined:
  - `scl_in` passes through a 2-flop synchronizer to give `scl_s` (reset value 1).
  - In Q2, `cnt` advances only while `scl_s` = 1.
  - With an ideal bus, Q2 lasts N+2 cycles (synchronizer latency), giving a period of 4N+2.
  - `stretch` = 1 while the state is Q2, `scl_s` = 0, and Q2 has already lasted at least 2 cycles. It deasserts the cycle after `scl_s` returns to 1.
- Undefined:
  - `scl_in` is ignored; the port remains.
  - Q2 lasts exactly N cycles.
  - `stretch` is tied to 0.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum (IDLE, Q0..Q3);
  - the constant `SYNC_STAGES` = 2.
- Sub-module `i2c_sync2`: a 2-flop synchronizer with reset value 1. It is reusable for SDA. It is instantiated only under `I2C_SCL_STRETCH_EN`.

## Test plan
- Reset, then `en` = 0 for 50 cycles: `scl_oe` = 0, `busy` = 0, no strobes.
- `div` = 4, `en` held 1, macro undefined:
  - `scl_oe` high for 8 cycles, low for 8, period 16.
  - Strobe order `fall`, `chg`, `rise`, `smp`, spaced 4 cycles apart.
- `div` = 0: treated as 1, period 4. Then `div` changes to 3 during Q1: the current period stays at 4, and the next period is 12.
- Macro defined, `div` = 4, `scl_in` = `~scl_oe`: period 18. Then hold `scl_in` = 0 for 20 cycles after `rise_stb`:
  - `stretch` asserts 2 cycles after `rise_stb`;
  - `smp_stb` fires 4 cycles after `scl_s` returns high.
- `en` pulsed for 1 cycle with `div` = 2: exactly one period of 8 cycles, then IDLE, with `busy` low after the final Q3.
- `rst_n` low during Q0: `scl_oe` and `busy` go to 0 immediately. After release, the first `fall_stb` comes 1 cycle after `en`.
